// File: rtl/jpeg_pkg.sv
// Shared constants for the JPEG quantizer: Annex K tables, reciprocals, FSM states.
package jpeg_pkg;

   localparam int DEF_BLOCK_SIZE = 64;
   localparam int IDX_W          = 6;
   localparam int TBL_Q_W        = 8;
   localparam int TBL_RECIP_W    = 16;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   typedef logic [TBL_RECIP_W:0]                r_val_t;
   typedef logic [0:63][TBL_Q_W-1:0]            q_table_t;
   typedef logic [0:63][TBL_RECIP_W:0]          r_table_t;

   localparam q_table_t LUMA_Q = {
      8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
      8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
      8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
      8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
      8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
      8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
      8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
      8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
   };

   localparam q_table_t CHROMA_Q = {
      8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99,
      8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99,
      8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
      8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
      {32{8'd99}}
   };

   // round(2^RECIP_W / q) evaluated at elaboration; no ties occur for 8-bit q
   function automatic r_table_t build_recip(input q_table_t qt);
      r_table_t rt;
      for (int i = 0; i < 64; i++) begin
         rt[i] = r_val_t'(((1 << (TBL_RECIP_W + 1)) + int'(qt[i])) / (2 * int'(qt[i])));
      end
      return rt;
   endfunction

   localparam r_table_t LUMA_R   = build_recip(LUMA_Q);
   localparam r_table_t CHROMA_R = build_recip(CHROMA_Q);

endpackage

// File: rtl/quant_table_rom.sv
// Registered (table_sel, idx) -> {q, reciprocal} lookup; forms pipeline stage S1.
module quant_table_rom
   import jpeg_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en_i,
   input  logic                   sel_i,
   input  logic [IDX_W-1:0]       idx_i,
   output logic [TBL_Q_W-1:0]     q_o,
   output logic [TBL_RECIP_W:0]   recip_o
);

   logic [TBL_Q_W-1:0]   q_q;
   logic [TBL_RECIP_W:0] recip_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q     <= '0;
         recip_q <= '0;
      end else if (en_i) begin
         q_q     <= sel_i ? CHROMA_Q[idx_i] : LUMA_Q[idx_i];
         recip_q <= sel_i ? CHROMA_R[idx_i] : LUMA_R[idx_i];
      end
   end

   assign q_o     = q_q;
   assign recip_o = recip_q;

endmodule

// File: rtl/jpeg_quantizer_stream.sv
// Streaming 8x8 JPEG quantizer: input register, S1 ROM/|x|, S2 multiply, S3 round/clamp.
//  state | meaning
//  IDLE  | waiting for start, no input accepted
//  RUN   | accepting/emitting one block until the last output is taken
module jpeg_quantizer_stream
   import jpeg_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int OUT_W      = 16,
   parameter int Q_W        = TBL_Q_W,
   parameter int RECIP_W    = TBL_RECIP_W,
   parameter int BLOCK_SIZE = DEF_BLOCK_SIZE
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              table_sel,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [5:0]        out_idx,
   output logic [Q_W-1:0]    out_q,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W  = $clog2(BLOCK_SIZE + 1);
   localparam int PROD_W = DATA_W + RECIP_W + 1;
   localparam logic [PROD_W-1:0] HALF    = PROD_W'(1) << (RECIP_W - 1);
   localparam logic [DATA_W:0]   MAX_MAG = (DATA_W + 1)'((1 << (OUT_W - 1)) - 1);

   state_t             state_q, state_d;
   logic               sel_q;
   logic [CNT_W-1:0]   in_cnt_q, out_cnt_q;
   logic               stall, in_acc, out_acc, last_out, done_q;

   logic               v0_q;
   logic [DATA_W-1:0]  x0_q;
   logic [IDX_W-1:0]   idx0_q;

   logic               v1_q, neg1_q;
   logic [DATA_W-1:0]  a1_q;
   logic [IDX_W-1:0]   idx1_q;
   logic [TBL_Q_W-1:0] rom_q;
   logic [TBL_RECIP_W:0] rom_r;

   logic               v2_q, neg2_q;
   logic [PROD_W-1:0]  prod2_q;
   logic [IDX_W-1:0]   idx2_q;
   logic [TBL_Q_W-1:0] q2_q;

   logic               out_valid_q;
   logic [OUT_W-1:0]   out_data_q;
   logic [IDX_W-1:0]   out_idx_q;
   logic [Q_W-1:0]     out_q_q;

   logic [DATA_W-1:0]  abs_x;
   logic [DATA_W:0]    m, mag;
   logic [OUT_W-1:0]   mag_o, res;

   assign stall    = out_valid_q && !out_ready;
   assign in_ready = (state_q == RUN) && (in_cnt_q < CNT_W'(BLOCK_SIZE)) && !stall;
   assign in_acc   = in_valid && in_ready;
   assign out_acc  = out_valid_q && out_ready;
   assign last_out = (state_q == RUN) && (out_cnt_q == CNT_W'(BLOCK_SIZE - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (out_acc && last_out) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sel_q     <= 1'b0;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= out_acc && last_out;
         if (state_q == IDLE && start) begin
            sel_q     <= table_sel;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
         end else begin
            if (in_acc)  in_cnt_q  <= in_cnt_q + 1'b1;
            if (out_acc) out_cnt_q <= out_cnt_q + 1'b1;
         end
      end
   end

   // two's-complement negate maps -2^(DATA_W-1) onto its unsigned magnitude
   assign abs_x = x0_q[DATA_W-1] ? (~x0_q + 1'b1) : x0_q;

   quant_table_rom u_rom (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (!stall),
      .sel_i   (sel_q),
      .idx_i   (idx0_q),
      .q_o     (rom_q),
      .recip_o (rom_r)
   );

   assign m     = (DATA_W + 1)'((prod2_q + HALF) >> RECIP_W);
   assign mag   = (m > MAX_MAG) ? MAX_MAG : m;
   assign mag_o = OUT_W'(mag);
   assign res   = neg2_q ? (~mag_o + 1'b1) : mag_o;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v0_q        <= 1'b0;
         x0_q        <= '0;
         idx0_q      <= '0;
         v1_q        <= 1'b0;
         a1_q        <= '0;
         neg1_q      <= 1'b0;
         idx1_q      <= '0;
         v2_q        <= 1'b0;
         prod2_q     <= '0;
         neg2_q      <= 1'b0;
         idx2_q      <= '0;
         q2_q        <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_q_q     <= '0;
      end else if (!stall) begin
         v0_q        <= in_acc;
         x0_q        <= in_data;
         idx0_q      <= IDX_W'(in_cnt_q);
         v1_q        <= v0_q;
         a1_q        <= abs_x;
         neg1_q      <= x0_q[DATA_W-1];
         idx1_q      <= idx0_q;
         v2_q        <= v1_q;
         prod2_q     <= PROD_W'(a1_q) * PROD_W'(rom_r);
         neg2_q      <= neg1_q;
         idx2_q      <= idx1_q;
         q2_q        <= rom_q;
         out_valid_q <= v2_q;
         out_data_q  <= res;
         out_idx_q   <= idx2_q;
         out_q_q     <= Q_W'(q2_q);
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_q     = out_q_q;
   assign busy      = (state_q == RUN);
   assign done      = done_q;

endmodule

// File: doc/jpeg_quantizer_stream.md
Name: jpeg_quantizer_stream

Overview:
Second-generation JPEG quantizer. It accepts one 8x8 block of DCT coefficients in raster order over a valid/ready stream and divides each coefficient by the matching entry of the selected table, luma or chroma (JPEG Annex K). Division is a rounding reciprocal multiply. Results go out on a backpressure-capable valid/ready stream to the zigzag/entropy stage, with the coefficient index and Q value alongside. It sits between the 2-D DCT and the zigzag reorder.

Parameters:
DATA_W, 16, signed DCT input width
OUT_W, 16, signed quantized output width (OUT_W <= DATA_W)
Q_W, 8, quantizer table entry width
RECIP_W, 16, reciprocal fraction bits; stored reciprocal is RECIP_W+1 bits
BLOCK_SIZE, 64, coefficients per block

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  pulse in IDLE begins a block
table_sel  in  1  0=luma, 1=chroma; sampled with start
in_data  in  DATA_W  signed DCT coefficient
in_valid  in  1  in_data valid
in_ready  out  1  block accepts in_data
out_data  out  OUT_W  signed quantized coefficient
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
out_idx  out  6  raster index of out_data
out_q  out  Q_W  Q value used for out_data (monitor)
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse after the last output is accepted

Behaviour:
- Reset is synchronous and active-low; it is sampled on the rising clk edge. All outputs reset to 0. State returns to IDLE. Counters and pipeline valids clear. Reset in the middle of a block discards that block, and no done is issued.
- Input accept: in_valid && in_ready at a rising edge. Output accept: out_valid && out_ready.
- FSM IDLE: in_ready=0. A start pulse latches table_sel, clears in_cnt and out_cnt, and moves to RUN.
- FSM RUN: in_ready = (in_cnt < BLOCK_SIZE) && !stall. When out_cnt reaches BLOCK_SIZE on an accepted output: done=1 for one cycle, busy=0, next state IDLE.
- start is ignored outside IDLE. in_valid is ignored when in_ready=0.
- Pipeline has 3 stages: S1 ROM lookup and |x|, S2 multiply, S3 round/shift/sign/clamp. Stage-3 registers drive the outputs.
- Latency: an input accepted at edge N appears with out_valid=1 after edge N+3 if there is no stall.
- Throughput: 1 coefficient/cycle.
- stall = out_valid && !out_ready. Stall freezes every stage, and no data is lost or duplicated.
- out_idx and out_q travel with the data through the pipeline.
- Arithmetic:
  - a = |x| as DATA_W-bit unsigned, so -2^(DATA_W-1) is legal.
  - R[q] = round(2^RECIP_W / q), stored on RECIP_W+1 bits (q=1 gives 2^RECIP_W).
  - m = (a*R + 2^(RECIP_W-1)) >> RECIP_W, using a DATA_W+RECIP_W+1 bit product.
  - Result = sign(x)*m, then symmetric clamp to ±(2^(OUT_W-1)-1).
- The reference model uses exactly this formula; results must be bit-exact.
- A Q entry of 0 never appears in the tables.

Decomposition:
- Shared package jpeg_pkg holds:
  - the luma and chroma Annex K Q tables (64 x Q_W each)
  - the precomputed reciprocal tables for RECIP_W=16
  - the state enum (IDLE, RUN)
  - the BLOCK_SIZE constant
- One sub-module, quant_table_rom: a registered lookup of (table_sel, idx) -> {q, R}, with 1-cycle latency, forming stage S1.

Test Plan:
- Luma ramp, no backpressure: start with table_sel=0, feed in_data[i] = i*10-320 with in_valid held high.
  - Idx0 (Q=16, R=4096): out_data=-20.
  - Idx1 (Q=11, R=5958): out_data=-28.
  - First out_valid 3 cycles after the first accept; 64 consecutive outputs.
  - done pulses once, on the cycle after the 64th accept.
- Chroma select: the same ramp with table_sel=1.
  - Idx0 (Q=17, R=3855): out_data=-19, out_q=17.
  - Idx63 (Q=99, in=310): out_data=3.
- Rounding boundary, luma idx0:
  - in=8 gives 1, in=7 gives 0, in=-8 gives -1, in=0 gives 0.
- Backpressure: toggle out_ready pseudo-randomly (~50%).
  - All 64 outputs match the model in index order.
  - out_data, out_idx and out_q are stable while stalled.
  - in_ready drops during stalls; done comes after the final accept.
- Saturation with OUT_W=8, luma idx0:
  - in=32767 gives 127.
  - in=-32768 gives -127.
- Reset and start protocol:
  - rst_n=0 for one cycle after 20 inputs: out_valid, in_ready, busy and done are 0 the next cycle; no done is issued for the aborted block.
  - A following start processes a full new block correctly.
  - A start pulse during RUN is ignored: the counts are unchanged.
